// File: rtl/spi_frame_pkg.sv
// Shared types and header field layout for the SPI frame assembler.
// Header byte: [7:5] chip id, [4:0] payload length.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TRUNC   = 2'd2
    } state_e;

    localparam int ID_MSB  = 7;
    localparam int ID_LSB  = 5;
    localparam int LEN_MSB = 4;
    localparam int LEN_LSB = 0;
    localparam int ID_W    = ID_MSB - ID_LSB + 1;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    localparam logic [7:0] DEF_IDLE_BYTE     = 8'hBC;
    localparam logic [7:0] DEF_IDLE_BYTE_ALT = 8'hFF;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] b);
        return b[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ID_W-1:0] hdr_id(input logic [7:0] b);
        return b[ID_MSB:ID_LSB];
    endfunction

endpackage

// File: rtl/spi_frame_assembler.sv
// Turns the raw SPI MISO byte stream into AXIS frame packets: strips idle
// filler, follows header lengths, and force-closes frames that stall.
module spi_frame_assembler
    import spi_frame_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE      = DEF_IDLE_BYTE,
    parameter logic [7:0] IDLE_BYTE_ALT  = DEF_IDLE_BYTE_ALT,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_err,
    output logic             in_frame
);

    // One extra bit so TIMEOUT_CYCLES itself is representable.
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic [7:0]        tdata_q;
    logic              tvalid_q, tlast_q, tuser_q;
    logic [CNT_W-1:0]  ok_q, err_q;

    logic              out_free, accept, stall, is_idle;
    logic [LEN_W-1:0]  hlen;

    logic              load, ld_last, ld_user, inc_ok, inc_err;
    logic [7:0]        ld_data;

    assign out_free      = !tvalid_q || m_axis_tready;
    assign stall         = tvalid_q && !m_axis_tready;
    assign s_axis_tready = (state_q != TRUNC) && out_free;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign is_idle       = (s_axis_tdata == IDLE_BYTE) || (s_axis_tdata == IDLE_BYTE_ALT);
    assign hlen          = hdr_len(s_axis_tdata);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            rem_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic; an accepted byte always takes priority over timeout.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        to_d    = to_q;
        case (state_q)
            HUNT: begin
                to_d = '0;
                if (accept && !is_idle && hlen != '0) begin
                    state_d = PAYLOAD;
                    rem_d   = hlen;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    to_d  = '0;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1))
                        state_d = HUNT;
                end else if (!stall) begin
                    if (to_q == TO_LAST) begin
                        state_d = TRUNC;
                        to_d    = '0;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
            TRUNC: begin
                if (out_free)
                    state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    // Output-register load decode
    always_comb begin
        load    = 1'b0;
        ld_data = s_axis_tdata;
        ld_last = 1'b0;
        ld_user = 1'b0;
        inc_ok  = 1'b0;
        inc_err = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept && !is_idle) begin
                    load = 1'b1;
                    if (hlen == '0) begin
                        ld_last = 1'b1;
                        ld_user = 1'b1;
                        inc_err = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    load = 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        ld_last = 1'b1;
                        inc_ok  = 1'b1;
                    end
                end
            end
            TRUNC: begin
                if (out_free) begin
                    load    = 1'b1;
                    ld_data = IDLE_BYTE;
                    ld_last = 1'b1;
                    ld_user = 1'b1;
                    inc_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Single-entry output register; a new load beats a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else if (load) begin
            tvalid_q <= 1'b1;
            tdata_q  <= ld_data;
            tlast_q  <= ld_last;
            tuser_q  <= ld_user;
        end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ok_q  <= '0;
            err_q <= '0;
        end else begin
            if (inc_ok)
                ok_q <= ok_q + CNT_W'(1);
            if (inc_err)
                err_q <= err_q + CNT_W'(1);
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frames_ok     = ok_q;
    assign frames_err    = err_q;
    assign in_frame      = (state_q == PAYLOAD) || (state_q == TRUNC);

endmodule
